// File: rtl/line_buffer_pkg.sv
// Shared constants for the 3x3 line-buffer window: default pixel width,
// window geometry, and the tap-to-bit-position packing of window_out.
package line_buffer_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned WIN_SIZE       = 3;
  localparam int unsigned WIN_TAPS       = WIN_SIZE * WIN_SIZE;

  // Tap idx = row*WIN_SIZE + col (row 0 = oldest line, col 0 = oldest column);
  // tap 0 sits in the MSBs so the newest pixel lands in the LSBs.
  function automatic int unsigned win_lsb(input int unsigned idx, input int unsigned dw);
    return (WIN_TAPS - 1 - idx) * dw;
  endfunction

endpackage

// File: rtl/line_fifo.sv
// Fixed-depth shift delay line: dout is the sample pushed DEPTH enables ago.
module line_fifo
  import line_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (en) begin
      mem[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/line_buffer.sv
// Streaming 3x3 window generator over a raster pixel stream using two row
// delay lines; emits one registered window per pixel with r>=2 and c>=2.
module line_buffer
  import line_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned IMG_WIDTH  = 4,
  parameter int unsigned IMG_HEIGHT = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pixel_valid,
  input  logic [DATA_WIDTH-1:0]          pixel_in,
  output logic                           window_valid,
  output logic [WIN_TAPS*DATA_WIDTH-1:0] window_out
);

  // IMG_WIDTH and IMG_HEIGHT are expected to be >= WIN_SIZE.
  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam int unsigned WIN_W = WIN_TAPS * DATA_WIDTH;
  localparam int unsigned HIST  = WIN_SIZE - 1;

  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [DATA_WIDTH-1:0] line1;
  logic [DATA_WIDTH-1:0] line2;
  logic [DATA_WIDTH-1:0] col_new_c [WIN_SIZE];
  logic [DATA_WIDTH-1:0] tap [WIN_SIZE][HIST];
  logic [WIN_W-1:0]      win_c;
  logic                  hit_c;
  logic                  col_last_c;
  logic                  row_last_c;

  // line1 yields pixel (r-1,c), line2 yields (r-2,c) for the pixel being accepted
  line_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH)
  ) u_line1 (
    .clk  (clk),
    .rst  (rst),
    .en   (pixel_valid),
    .din  (pixel_in),
    .dout (line1)
  );

  line_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH)
  ) u_line2 (
    .clk  (clk),
    .rst  (rst),
    .en   (pixel_valid),
    .din  (line1),
    .dout (line2)
  );

  always_comb begin
    col_new_c[0] = line2;
    col_new_c[1] = line1;
    col_new_c[2] = pixel_in;
  end

  // Assemble the window as it will look once the current pixel is accepted
  always_comb begin
    win_c = '0;
    for (int unsigned i = 0; i < WIN_SIZE; i++) begin
      for (int unsigned j = 0; j < HIST; j++) begin
        win_c[win_lsb(i*WIN_SIZE + j, DATA_WIDTH) +: DATA_WIDTH] = tap[i][j];
      end
      win_c[win_lsb(i*WIN_SIZE + HIST, DATA_WIDTH) +: DATA_WIDTH] = col_new_c[i];
    end
  end

  always_comb begin
    col_last_c = (col == COL_W'(IMG_WIDTH - 1));
    row_last_c = (row == ROW_W'(IMG_HEIGHT - 1));
    hit_c      = pixel_valid && (row >= ROW_W'(HIST)) && (col >= COL_W'(HIST));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (pixel_valid) begin
      if (col_last_c) begin
        col <= '0;
        row <= row_last_c ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Column history per window row; stale data across row/frame edges is masked by hit_c
  always_ff @(posedge clk) begin
    if (!rst) begin
      window_valid <= 1'b0;
      window_out   <= '0;
      for (int unsigned i = 0; i < WIN_SIZE; i++) begin
        for (int unsigned j = 0; j < HIST; j++) begin
          tap[i][j] <= '0;
        end
      end
    end else begin
      window_valid <= hit_c;
      if (hit_c) begin
        window_out <= win_c;
      end
      if (pixel_valid) begin
        for (int unsigned i = 0; i < WIN_SIZE; i++) begin
          for (int unsigned j = 0; j + 1 < HIST; j++) begin
            tap[i][j] <= tap[i][j+1];
          end
          tap[i][HIST-1] <= col_new_c[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_line_buffer.sv
// Self-checking bench for line_buffer: frame model + scoreboard queue,
// a vector table for the plain ramp, and hand sequences for gaps/frames/reset.
module tb_line_buffer;
  import line_buffer_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 4;
  localparam int unsigned IH = 4;
  localparam int unsigned WW = WIN_TAPS * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          pixel_valid;
  logic [DW-1:0] pixel_in;
  logic          window_valid;
  logic [WW-1:0] window_out;

  line_buffer #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pixel_valid  (pixel_valid),
    .pixel_in     (pixel_in),
    .window_valid (window_valid),
    .window_out   (window_out)
  );

  always #5 clk = ~clk;

  int            checks   = 0;
  int            failures = 0;
  int            pulses   = 0;
  int            mr       = 0;
  int            mc       = 0;
  logic [WW-1:0] sb [$];
  logic [DW-1:0] frame_m [IH][IW];
  logic [WW-1:0] last_out = '0;

  typedef struct {
    bit            v;
    logic [DW-1:0] d;
    bit            exp_v;
    logic [WW-1:0] exp_w;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Window whose top-left pixel is t in a ramp-filled IW-wide frame
  function automatic logic [WW-1:0] mkwin(input int t);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w[(8 - (i*3 + j))*DW +: DW] = DW'(t + i*int'(IW) + j);
      end
    end
    return w;
  endfunction

  function automatic logic [WW-1:0] model_win();
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w[(8 - (i*3 + j))*DW +: DW] = frame_m[mr-2+i][mc-2+j];
      end
    end
    return w;
  endfunction

  // One clock: drive, update model/scoreboard, then check outputs after the edge
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit rv);
    bit exp_v;
    exp_v       = 1'b0;
    pixel_valid = v;
    pixel_in    = d;
    rst         = rv;
    if (!rv) begin
      mr = 0;
      mc = 0;
      last_out = '0;
      sb.delete();
    end else if (v) begin
      frame_m[mr][mc] = d;
      if (mr >= 2 && mc >= 2) begin
        sb.push_back(model_win());
        exp_v = 1'b1;
      end
      if (mc == int'(IW) - 1) begin
        mc = 0;
        mr = (mr == int'(IH) - 1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
    @(posedge clk);
    #1;
    check("valid", WW'(window_valid), WW'(exp_v));
    if (window_valid === 1'b1) begin
      pulses++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_window actual=%h required=none", window_out);
      end else begin
        last_out = sb.pop_front();
        check("window", window_out, last_out);
      end
    end else begin
      check("hold", window_out, last_out);
    end
  endtask

  initial begin
    pixel_valid = 1'b0;
    pixel_in    = '0;
    rst         = 1'b0;

    // Reset state
    repeat (2) cycle(1'b0, '0, 1'b0);
    check("reset_valid", WW'(window_valid), '0);
    check("reset_out", window_out, '0);

    // Continuous ramp from the vector table
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{1'b1, DW'(i), 1'b0, '0};
    end
    tbl[10].exp_v = 1'b1; tbl[10].exp_w = mkwin(0);
    tbl[11].exp_v = 1'b1; tbl[11].exp_w = mkwin(1);
    tbl[14].exp_v = 1'b1; tbl[14].exp_w = mkwin(4);
    tbl[15].exp_v = 1'b1; tbl[15].exp_w = mkwin(5);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].v, tbl[i].d, 1'b1);
      check("tbl_valid", WW'(window_valid), WW'(tbl[i].exp_v));
      if (tbl[i].exp_v) check("tbl_window", window_out, tbl[i].exp_w);
    end
    check("ramp_pulses", WW'(pulses), WW'(4));

    // Same ramp with random idle gaps
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) cycle(1'b0, DW'($urandom), 1'b1);
      end
      cycle(1'b1, DW'(i), 1'b1);
      if (i == 15) check("gap_last_window", window_out, mkwin(5));
    end
    check("gap_pulses", WW'(pulses), WW'(4));

    // Two back-to-back frames
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, DW'(i), 1'b1);
      if (i == 12 || i == 13) check("row3_c_lt2_valid", WW'(window_valid), '0);
      if (i == 26) check("frame2_first", window_out, mkwin(16));
    end
    check("two_frame_pulses", WW'(pulses), WW'(8));

    // Mid-frame reset after pixel 7
    for (int i = 0; i < 8; i++) cycle(1'b1, DW'(i), 1'b1);
    cycle(1'b1, DW'($urandom), 1'b0);
    check("midrst_valid", WW'(window_valid), '0);
    check("midrst_out", window_out, '0);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, DW'(i), 1'b1);
      if (i == 10) check("post_rst_first", window_out, mkwin(0));
    end
    check("post_rst_pulses", WW'(pulses), WW'(4));

    // Held reset ignores valid pixels
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, DW'($urandom), 1'b0);
      check("rst_hold_valid", WW'(window_valid), '0);
      check("rst_hold_out", window_out, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_buffer.md
LINE_BUFFER -- requirements
Module: line_buffer

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning pixel width in bits.
REQ-002 The module SHALL have parameter IMG_WIDTH, default 4, meaning pixels per image row.
REQ-003 The module SHALL have parameter IMG_HEIGHT, default 4, meaning rows per frame.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge triggered.
REQ-005 The module SHALL have port rst, input, 1 bit, reset; one clock, reset is synchronous and active-low (asserted when 0).
REQ-006 The module SHALL have port pixel_valid, input, 1 bit, qualifying pixel_in for the current cycle.
REQ-007 The module SHALL have port pixel_in, input, DATA_WIDTH bits, raster-order pixel stream (row-major, left to right).
REQ-008 The module SHALL have port window_valid, output, 1 bit, meaning window_out holds a new complete 3x3 window this cycle.
REQ-009 The module SHALL have port window_out, output, 9*DATA_WIDTH bits, the flattened 3x3 window.

Function
REQ-010 A pixel SHALL be accepted on every rising clk edge with pixel_valid=1 and rst=1; there is no backpressure.
REQ-011 Internal column counter c (0..IMG_WIDTH-1) and row counter r (0..IMG_HEIGHT-1) SHALL give the position of the accepted pixel; c wraps to 0 and r increments at row end; both wrap to 0 after pixel (IMG_HEIGHT-1, IMG_WIDTH-1), so the next pixel starts a new frame.
REQ-012 Cycles with pixel_valid=0 SHALL change no state; counters, line storage and window_out hold, and window_valid=0.
REQ-013 On accepting pixel (r,c) with r>=2 and c>=2, window_valid SHALL be 1 in the following cycle (latency 1 registered cycle) and window_out SHALL hold pixels rows r-2..r, columns c-2..c.
REQ-014 Window packing SHALL be window_out = {w0,w1,...,w8}, w0 in bits [9*DATA_WIDTH-1 -: DATA_WIDTH]; w0..w2 = row r-2 (cols c-2,c-1,c), w3..w5 = row r-1, w6..w8 = row r; w8 = newest pixel.
REQ-015 window_valid SHALL be 0 for every accepted pixel with r<2 or c<2; no window spans a row boundary or a frame boundary.
REQ-016 window_valid SHALL be a one-cycle pulse per qualifying pixel; consecutive qualifying pixels produce back-to-back pulses.
REQ-017 window_out SHALL hold its last value while window_valid=0.
REQ-018 Line storage SHALL be two row delay lines of IMG_WIDTH entries each (row r-1 and row r-2 data), with no frame-level buffering.

Reset
REQ-019 While rst=0 at a rising edge, counters SHALL clear to 0, window_valid SHALL be 0, window_out SHALL be all zeros, and line storage and window registers SHALL clear to 0.
REQ-020 Reset asserted mid-frame SHALL abandon the frame; the first pixel after release is (0,0).

Structure
REQ-021 DATA_WIDTH default, window size 3 and the window packing order SHALL be defined in a shared package (line_buffer_pkg).
REQ-022 One sub-module, line_fifo (IMG_WIDTH-deep DATA_WIDTH shift delay line with enable), SHALL be instantiated twice; the 3x3 window register and counters live in line_buffer.
REQ-023 The implementation SHALL be fully synchronous, with no latches and no combinational path from inputs to outputs.

Verification
REQ-024 Feed 4x4 ramp 0..15 continuously -> exactly 4 window_valid pulses: {0,1,2,4,5,6,8,9,10}, {1,2,3,5,6,7,9,10,11}, {4,5,6,8,9,10,12,13,14}, {5,6,7,9,10,11,13,14,15}, each one cycle after pixels 10, 11, 14, 15.
REQ-025 Same ramp with pixel_valid=0 gaps of 1-3 cycles inserted randomly -> identical 4 windows in order, window_valid=0 during gaps, window_out stable.
REQ-026 Pixels 12 and 13 (row 3, c<2) -> window_valid=0 on the following cycles, with no row-spanning window.
REQ-027 Two back-to-back frames 0..15 then 16..31 -> second frame's first window is {16,17,18,20,21,22,24,25,26}, with no window mixing frames.
REQ-028 rst=0 for one cycle after pixel 7, then feed 0..15 -> window_out=0 and window_valid=0 during reset; afterwards the same 4 windows as REQ-024.
REQ-029 Under rst=0 with pixel_valid=1 and random data -> window_valid stays 0 and window_out stays 0.
